seq_nonrestoring_divider: RTL and testbench



---
 rtl/seq_nonrestoring_divider.sv | 148 ++++++++++++++
 tb/tb_seq_nonrestoring_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_nonrestoring_divider.sv
// Iterative N-bit non-restoring divider: one quotient bit per clock, then a
// single remainder-correction cycle and a one-cycle done pulse.
// Optional macro SIGNED_DIV_EN: two's-complement operands, truncating toward
// zero, remainder takes the sign of the dividend. Undefined: unsigned only.
module seq_nonrestoring_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [N:0]      p_q;     // signed partial remainder
  logic [N-1:0]    q_q;     // dividend shifting out / quotient shifting in
  logic [N-1:0]    d_q;     // divisor magnitude
  logic [CntW-1:0] cnt_q;
  logic            zero_q;  // divisor was zero; FIX emits the dbz result

  logic            div_zero;
  logic            last_iter;
  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      p_shift, p_next, p_fix;
  logic [N-1:0]    q_next, q_res, r_res;

  assign div_zero  = (divisor == '0);
  assign last_iter = (cnt_q == CntW'(N - 1));

`ifdef SIGNED_DIV_EN
  logic sq_q, sr_q;

  assign a_mag = dividend[N-1] ? -dividend : dividend;
  assign b_mag = divisor[N-1] ? -divisor : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  // One non-restoring step: shift {P,Q}, add or subtract D by the old sign of P
  always_comb begin
    p_shift = {p_q[N-1:0], q_q[N-1]};
    p_next  = p_q[N] ? (p_shift + {1'b0, d_q}) : (p_shift - {1'b0, d_q});
    q_next  = {q_q[N-2:0], ~p_next[N]};
    p_fix   = p_q[N] ? (p_q + {1'b0, d_q}) : p_q;
`ifdef SIGNED_DIV_EN
    q_res   = sq_q ? -q_q : q_q;
    r_res   = sr_q ? -p_fix[N-1:0] : p_fix[N-1:0];
`else
    q_res   = q_q;
    r_res   = p_fix[N-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; divide-by-zero still passes through FIX so its done
  // pulse lands one cycle later than the accepting edge plus one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = div_zero ? StFix : StRun;
      StRun:   if (last_iter) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == StRun) || (state_q == StFix);
    done = (state_q == StDone);
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            p_q    <= '0;
            cnt_q  <= '0;
            zero_q <= div_zero;
            if (div_zero) begin
              // Raw dividend is parked in Q to become the remainder
              q_q <= dividend;
              d_q <= '0;
            end else begin
              q_q <= a_mag;
              d_q <= b_mag;
              dbz <= 1'b0;
            end
`ifdef SIGNED_DIV_EN
            sq_q <= dividend[N-1] ^ divisor[N-1];
            sr_q <= dividend[N-1];
`endif
          end
        end
        StRun: begin
          p_q   <= p_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 1'b1;
        end
        StFix: begin
          if (zero_q) begin
            quotient  <= '1;
            remainder <= q_q;
            dbz       <= 1'b1;
          end else begin
            quotient  <= q_res;
            remainder <= r_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Directed bench for seq_nonrestoring_divider at N=8 (unsigned or SIGNED_DIV_EN).
module tb_seq_nonrestoring_divider;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend, divisor;
  logic         busy, done, dbz;
  logic [N-1:0] quotient, remainder;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  seq_nonrestoring_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Called just after a posedge in an IDLE cycle; that edge-to-come is edge k
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles (sampled on negedge) until done; busy must be high until then
  task automatic wait_done(input int budget, output int lat, output int busy_bad);
    lat      = 0;
    busy_bad = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done) begin
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (lat >= budget) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, bb;
    start_op(v.a, v.b);
    wait_done(40, lat, bb);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " busy"}, bb, 0);
    check({tag, " quotient"}, int'(quotient), int'(v.q));
    check({tag, " remainder"}, int'(remainder), int'(v.r));
    check({tag, " dbz"}, int'(dbz), int'(v.z));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bb, pulses;
    logic [7:0] exp_q, exp_r;

`ifdef SIGNED_DIV_EN
    vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10});
    vecs.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10});
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10});
    vecs.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 10});
    vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 10});
    vecs.push_back('{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 2});
    vecs.push_back('{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 2});
    vecs.push_back('{8'h09, 8'h03, 8'h03, 8'h00, 1'b0, 10});
    exp_q = 8'hFA;  // -56 / 9
    exp_r = 8'hFE;
`else
    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 10});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 10});
    vecs.push_back('{8'd3,   8'd200, 8'd0,   8'd3,   1'b0, 10});
    vecs.push_back('{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 2});
    vecs.push_back('{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 10});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 10});
    vecs.push_back('{8'd7,   8'd7,   8'd1,   8'd0,   1'b0, 10});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 10});
    vecs.push_back('{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 10});
    exp_q = 8'd22;  // 200 / 9
    exp_r = 8'd2;
`endif

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset dbz", int'(dbz), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back operations: each start lands in the IDLE cycle after DONE
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed again while busy must be ignored
    start_op(8'd200, 8'd9);
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, lat, bb);
    check("ignored latency", lat, 7);
    check("ignored busy", bb, 0);
    check("ignored quotient", int'(quotient), int'(exp_q));
    check("ignored remainder", int'(remainder), int'(exp_r));
    repeat (5) @(negedge clk);
    check("hold quotient", int'(quotient), int'(exp_q));
    check("hold remainder", int'(remainder), int'(exp_r));
    check("hold done", int'(done), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation
    start_op(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst quotient", int'(quotient), 0);
    check("midrst remainder", int'(remainder), 0);
    check("midrst dbz", int'(dbz), 0);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no_done", pulses, 0);
    @(posedge clk);
    #1;
    run_vec('{8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 10}, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
